// File: rtl/bit_packer.sv
// Serial-to-parallel collector: gathers WIDTH accepted bits into a word and
// presents it on a registered valid/ready port, overlapping input with output.
module bit_packer #(
    parameter int unsigned WIDTH     = 3,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_bit,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out_vec,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(WIDTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] acc_q, acc_d, acc_ins;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             in_acc, out_xfer, slot_free;

    always_comb begin
        in_acc      = in_valid && (cnt_q != FULL_CNT);
        out_xfer    = out_valid_q && out_ready;
        slot_free   = !out_valid_q || out_xfer;

        acc_ins = acc_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (cnt_q == CW'(MSB_FIRST ? (WIDTH - 1 - i) : i))
                acc_ins[i] = in_bit;
        end

        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        if (out_xfer)
            out_valid_d = 1'b0;

        if (cnt_q == FULL_CNT) begin
            // Word parked in acc waits for the slot; input is stalled meanwhile.
            if (out_xfer) begin
                out_d       = acc_q;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end
        end else if (in_acc) begin
            if (cnt_q == LAST_CNT) begin
                if (slot_free) begin
                    out_d       = acc_ins;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                end else begin
                    acc_d = acc_ins;
                    cnt_d = FULL_CNT;
                end
            end else begin
                acc_d = acc_ins;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (cnt_q != FULL_CNT);
    assign out_vec   = out_q;
    assign out_valid = out_valid_q;
    assign count     = cnt_q;

endmodule

// File: tb/tb_bit_packer.sv
// Directed bench for bit_packer: LSB-first and MSB-first WIDTH=3 instances
// plus a WIDTH=1 instance share one input stream.
module tb_bit_packer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_bit = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic one = 1'b1;

    logic       l_in_ready, l_out_valid, m_in_ready, m_out_valid;
    logic [2:0] l_out_vec, m_out_vec;
    logic [1:0] l_count, m_count;
    logic       w_in_ready, w_out_valid;
    logic [0:0] w_out_vec, w_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_packer #(.WIDTH(3), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(l_in_ready), .out_vec(l_out_vec), .out_valid(l_out_valid),
        .out_ready(out_ready), .count(l_count)
    );

    bit_packer #(.WIDTH(3), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(m_in_ready), .out_vec(m_out_vec), .out_valid(m_out_valid),
        .out_ready(out_ready), .count(m_count)
    );

    bit_packer #(.WIDTH(1), .MSB_FIRST(1'b0)) dut_w1 (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(w_in_ready), .out_vec(w_out_vec), .out_valid(w_out_valid),
        .out_ready(one), .count(w_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
    endtask

    logic [8:0] pat;
    logic [2:0] exp_words [3];
    int words, ready_low, long_pulse, j;
    logic prev_valid;

    initial begin
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("reset_out_valid", l_out_valid, 0);
        chk("reset_out_vec", l_out_vec, 0);
        chk("reset_count", l_count, 0);
        chk("reset_in_ready", l_in_ready, 1);

        // LSB-first / MSB-first / WIDTH=1: stream 1,1,0 with out_ready high
        out_ready = 1'b1;
        send(1'b1);
        chk("w1_vec_first", w_out_vec, 1);
        chk("w1_valid_first", w_out_valid, 1);
        chk("lsb_count_1", l_count, 1);
        send(1'b1);
        send(1'b0);
        chk("lsb_valid", l_out_valid, 1);
        chk("lsb_vec", l_out_vec, 3'b011);
        chk("lsb_count", l_count, 0);
        chk("msb_vec", m_out_vec, 3'b110);
        chk("msb_valid", m_out_valid, 1);
        chk("w1_vec_third", w_out_vec, 0);
        in_valid = 1'b0;
        tick();
        chk("drain_valid_low", l_out_valid, 0);
        chk("drain_vec_kept", l_out_vec, 3'b011);
        chk("w1_drain_valid", w_out_valid, 0);

        // Backpressure: 1,0,0 held, then 0,1,1 parks in the accumulator
        out_ready = 1'b0;
        send(1'b1);
        send(1'b0);
        send(1'b0);
        chk("bp_word1_valid", l_out_valid, 1);
        chk("bp_word1_vec", l_out_vec, 3'b001);
        chk("bp_word1_msb", m_out_vec, 3'b100);
        send(1'b0);
        send(1'b1);
        send(1'b1);
        chk("bp_full_count", l_count, 3);
        chk("bp_full_in_ready", l_in_ready, 0);
        chk("bp_full_held_vec", l_out_vec, 3'b001);
        out_ready = 1'b1;
        in_bit = 1'b1;
        tick();
        chk("bp_release_vec", l_out_vec, 3'b110);
        chk("bp_release_msb", m_out_vec, 3'b011);
        chk("bp_release_valid", l_out_valid, 1);
        chk("bp_release_in_ready", l_in_ready, 1);
        chk("bp_release_count", l_count, 0);
        out_ready = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("bp_ignored_bit_count", l_count, 0);
        chk("bp_hold_vec", l_out_vec, 3'b110);

        // Word A (110) held; word B 1,0,1 completes on the drain cycle
        send(1'b1);
        chk("sim_valid_b0", l_out_valid, 1);
        send(1'b0);
        chk("sim_valid_b1", l_out_valid, 1);
        out_ready = 1'b1;
        send(1'b1);
        chk("sim_vec_b", l_out_vec, 3'b101);
        chk("sim_valid_b2", l_out_valid, 1);
        chk("sim_count", l_count, 0);
        chk("sim_in_ready", l_in_ready, 1);
        in_valid = 1'b0;
        tick();
        chk("sim_drained", l_out_valid, 0);

        // Reset mid-word while a word is held
        out_ready = 1'b0;
        send(1'b1);
        send(1'b1);
        send(1'b1);
        send(1'b0);
        send(1'b1);
        chk("pre_rst_count", l_count, 2);
        chk("pre_rst_valid", l_out_valid, 1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", l_out_valid, 0);
        chk("rst_async_vec", l_out_vec, 0);
        chk("rst_async_count", l_count, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", l_in_ready, 1);
        out_ready = 1'b1;
        send(1'b0);
        send(1'b0);
        send(1'b1);
        chk("rst_fresh_vec", l_out_vec, 3'b100);
        chk("rst_fresh_msb", m_out_vec, 3'b001);
        chk("rst_fresh_valid", l_out_valid, 1);
        in_valid = 1'b0;
        tick();

        // Continuous stream, in_valid toggling, out_ready high
        pat = 9'b100_011_101;
        exp_words[0] = 3'b101;
        exp_words[1] = 3'b011;
        exp_words[2] = 3'b100;
        words = 0;
        ready_low = 0;
        long_pulse = 0;
        prev_valid = 1'b0;
        j = 0;
        for (int i = 0; i < 18; i++) begin
            if (l_in_ready !== 1'b1) ready_low++;
            in_valid = (i % 2 == 0);
            in_bit = pat[j];
            if (i % 2 == 0) j++;
            tick();
            if (l_out_valid === 1'b1) begin
                if (prev_valid) long_pulse++;
                if (words < 3) chk("stream_word", l_out_vec, exp_words[words]);
                words++;
            end
            prev_valid = l_out_valid;
        end
        in_valid = 1'b0;
        chk("stream_word_count", words, 3);
        chk("stream_in_ready_low", ready_low, 0);
        chk("stream_long_pulse", long_pulse, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
